// File: rtl/dpot_arbiter.sv
// Round-robin arbiter that serializes wiper writes from NREQ requesters onto one digital-pot port.
// A skipped write acks 3 cycles after the request; a real write waits on the synchronized ready handshake, bounded by TIMEOUT.
module dpot_arbiter #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 1023,
  parameter int SKIP_SAME = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] value_i,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              busy,
  output logic [7:0]        dpot_value,
  output logic              dpot_update,
  input  logic              dpot_ready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic            rdy_meta_q;
  logic            rdy_s_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] ack_q;
  logic            err_q;
  logic            upd_q;
  logic [7:0]      val_q;
  logic [7:0]      last_val_q;
  logic            last_valid_q;

  logic            rr_hit;
  logic [PW-1:0]   rr_win;
  logic [7:0]      grant_val;
  logic [NREQ-1:0] win_oh;

  // Scan offsets from ptr outward; the first set request wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!rr_hit && req[j] && (((int'(ptr_q) + i) % NREQ) == j)) begin
          rr_hit = 1'b1;
          rr_win = PW'(j);
        end
      end
    end
  end

  always_comb begin
    grant_val = '0;
    win_oh    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_q == PW'(j)) begin
        grant_val = value_i[8*j +: 8];
        win_oh[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rdy_meta_q   <= 1'b1;
      rdy_s_q      <= 1'b1;
      ptr_q        <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      upd_q        <= 1'b0;
      val_q        <= '0;
      last_val_q   <= '0;
      last_valid_q <= 1'b0;
    end else begin
      rdy_meta_q <= dpot_ready;
      rdy_s_q    <= rdy_meta_q;
      ack_q      <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (rr_hit && rdy_s_q) begin
            win_q   <= rr_win;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          val_q <= grant_val;
          cnt_q <= '0;
          if ((SKIP_SAME != 0) && last_valid_q && (grant_val == last_val_q)) begin
            ack_q   <= win_oh;
            state_q <= S_DONE;
          end else begin
            upd_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The pot dropping ready means it took the write; that wins over an expiring count.
          if (!rdy_s_q) begin
            upd_q   <= 1'b0;
            state_q <= S_WAIT;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            upd_q   <= 1'b0;
            err_q   <= 1'b1;
            ack_q   <= win_oh;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (rdy_s_q) begin
            last_val_q   <= val_q;
            last_valid_q <= 1'b1;
            ack_q        <= win_oh;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          ptr_q   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE);
  assign dpot_value  = val_q;
  assign dpot_update = upd_q;

endmodule

// File: tb/tb_dpot_arbiter.sv
// Directed and randomized bench for dpot_arbiter against a transaction-level arbitration model.
module tb_dpot_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] value_i;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic [7:0]  dpot_value;
  logic        dpot_update;
  logic        dpot_ready;

  logic [1:0]  req_b;
  logic [15:0] value_b;
  logic [1:0]  ack_b;
  logic        err_b;
  logic        busy_b;
  logic [7:0]  dpot_value_b;
  logic        dpot_update_b;

  int checks = 0;
  int errors = 0;

  // pot model state
  int         dp_lat    = 4;
  bit         dp_stuck  = 1'b0;
  int         dp_writes = 0;
  logic [7:0] dp_last   = 8'h00;

  // reference arbitration model
  int         m_ptr   = 0;
  logic [7:0] m_last  = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_err   = 1'b0;

  logic [3:0] a;
  int         cyc, upd, wr0, bad, c, acks, r;
  logic [7:0] saved, vb;

  dpot_arbiter #(.NREQ(4), .TIMEOUT(15), .SKIP_SAME(1)) dut (
    .clk(clk), .rst(rst), .req(req), .value_i(value_i), .ack(ack), .err(err), .busy(busy),
    .dpot_value(dpot_value), .dpot_update(dpot_update), .dpot_ready(dpot_ready)
  );

  dpot_arbiter #(.NREQ(2), .TIMEOUT(15), .SKIP_SAME(0)) dut_ns (
    .clk(clk), .rst(rst), .req(req_b), .value_i(value_b), .ack(ack_b), .err(err_b), .busy(busy_b),
    .dpot_value(dpot_value_b), .dpot_update(dpot_update_b), .dpot_ready(dpot_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pot: accepts an update while ready, drops ready after 2 cycles, returns it dp_lat cycles later.
  initial begin
    dpot_ready = 1'b1;
    forever begin
      @(negedge clk);
      if ((dpot_update || dpot_update_b) && dpot_ready && !dp_stuck) begin
        dp_writes++;
        dp_last = dpot_update ? dpot_value : dpot_value_b;
        repeat (2) @(negedge clk);
        dpot_ready = 1'b0;
        repeat (dp_lat) @(negedge clk);
        dpot_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] set);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = (m_ptr + i) % 4;
      if (set[k[1:0]]) return k;
    end
    return 0;
  endfunction

  task automatic set_val(input int k, input logic [7:0] v);
    value_i = (value_i & ~(32'hFF << (8 * k))) | ({24'b0, v} << (8 * k));
  endtask

  task automatic wait_ack(input bit use_b, input int budget, output logic [3:0] ao,
                          output int cy, output int up);
    ao = 4'b0;
    cy = 0;
    up = 0;
    while (ao == 4'b0 && cy < budget) begin
      @(negedge clk);
      cy++;
      if (use_b ? dpot_update_b : dpot_update) up++;
      ao = use_b ? {2'b00, ack_b} : ack;
    end
  endtask

  // One arbitration round on the main instance, checked against the model.
  task automatic serve(input string tag, input bit drop, output logic [3:0] ao,
                       output int cy, output int up);
    int         w;
    int         w0;
    logic [31:0] sh;
    logic [7:0] v;
    bit         expw;
    w    = pick(req);
    sh   = value_i >> (8 * w);
    v    = sh[7:0];
    expw = !(m_valid && (v == m_last));
    w0   = dp_writes;
    wait_ack(1'b0, 100, ao, cy, up);
    check($sformatf("%s_ack", tag), 32'(ao), 32'(4'b0001 << w));
    check($sformatf("%s_value", tag), 32'(dpot_value), 32'(v));
    check($sformatf("%s_busy", tag), 32'(busy), 32'd1);
    if (expw && dp_stuck) m_err = 1'b1;
    check($sformatf("%s_err", tag), 32'(err), 32'(m_err));
    if (!dp_stuck) begin
      check($sformatf("%s_writes", tag), 32'(dp_writes - w0), expw ? 32'd1 : 32'd0);
      if (expw) check($sformatf("%s_written", tag), 32'(dp_last), 32'(v));
    end
    if (expw && !dp_stuck) begin
      m_last  = v;
      m_valid = 1'b1;
    end
    m_ptr = (w + 1) % 4;
    if (drop) req = req & ~(4'b0001 << w);
    @(negedge clk);
    check($sformatf("%s_pulse", tag), 32'(ack), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req = '0; value_i = '0; req_b = '0; value_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_upd", 32'(dpot_update), 32'd0);
    check("rst_value", 32'(dpot_value), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Contention: all four held, each dropped on its own ack.
    value_i = 32'h44332211;
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      serve("cont", 1'b1, a, cyc, upd);
      check("cont_order", 32'(a), 32'(4'b0001 << k));
    end

    // A requester that keeps req high after its ack must yield to the other.
    req = 4'b0011;
    serve("rearm0", 1'b0, a, cyc, upd);
    serve("rearm1", 1'b1, a, cyc, upd);
    check("rearm_other_wins", 32'(a), 32'h2);
    serve("rearm2", 1'b1, a, cyc, upd);

    // Single request.
    dp_lat = 4;
    set_val(0, 8'h5A);
    req = 4'b0001;
    serve("single", 1'b1, a, cyc, upd);
    check("single_upd_seen", 32'(upd != 0), 32'd1);

    // Skip of a repeated value.
    set_val(0, 8'h20);
    req = 4'b0001;
    serve("skip_first", 1'b1, a, cyc, upd);
    req = 4'b0001;
    serve("skip_again", 1'b1, a, cyc, upd);
    check("skip_latency", 32'(cyc + 1), 32'd3);
    check("skip_no_upd", 32'(upd), 32'd0);

    // Same pair with skipping disabled: second write is a full transfer.
    value_b = 16'h0020;
    req_b = 2'b01;
    wait_ack(1'b1, 100, a, cyc, upd);
    req_b = 2'b00;
    check("ns_first_ack", 32'(a), 32'h1);
    @(negedge clk);
    wr0 = dp_writes;
    req_b = 2'b01;
    wait_ack(1'b1, 100, a, cyc, upd);
    req_b = 2'b00;
    check("ns_second_ack", 32'(a), 32'h1);
    check("ns_second_write", 32'(dp_writes - wr0), 32'd1);
    check("ns_second_upd", 32'(upd != 0), 32'd1);
    check("ns_second_slow", 32'(cyc + 1 > 3), 32'd1);
    check("ns_value", 32'(dpot_value_b), 32'h20);
    @(negedge clk);

    // Value and req change after grant must not disturb the transfer.
    set_val(0, 8'h10);
    req = 4'b0001;
    wr0 = dp_writes;
    @(negedge clk);
    @(negedge clk);
    set_val(0, 8'h99);
    req = 4'b0000;
    bad = 0;
    a = 4'b0;
    for (int k = 0; k < 100 && a == 4'b0; k++) begin
      @(negedge clk);
      if (dpot_value !== 8'h10) bad++;
      a = ack;
    end
    check("vchg_stable", 32'(bad), 32'd0);
    check("vchg_ack", 32'(a), 32'h1);
    check("vchg_writes", 32'(dp_writes - wr0), 32'd1);
    check("vchg_written", 32'(dp_last), 32'h10);
    m_last = 8'h10; m_valid = 1'b1; m_ptr = 1;
    @(negedge clk);

    // Randomized bursts.
    for (int it = 0; it < 25; it++) begin
      dp_lat = $urandom_range(4, 7);
      for (int k = 0; k < 4; k++) begin
        r  = $urandom_range(0, 3);
        vb = (r == 0) ? m_last : (r == 1) ? 8'h20 : 8'($urandom);
        set_val(k, vb);
      end
      req = 4'($urandom_range(1, 15));
      while (req != 4'b0) serve("rand", 1'b1, a, cyc, upd);
    end

    // Timeout with ready stuck high; last value must survive.
    dp_stuck = 1'b1;
    saved = m_last;
    set_val(0, saved ^ 8'hFF);
    req = 4'b0001;
    serve("tmo", 1'b1, a, cyc, upd);
    check("tmo_upd_cycles", 32'(upd), 32'd15);
    dp_stuck = 1'b0;
    set_val(0, saved);
    req = 4'b0001;
    serve("tmo_last", 1'b1, a, cyc, upd);
    check("tmo_last_no_upd", 32'(upd), 32'd0);

    // Reset while waiting for ready to return.
    dp_lat = 10;
    set_val(1, 8'h66);
    req = 4'b0010;
    c = 0;
    while (dpot_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_upd", 32'(dpot_update), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_upd", 32'(dpot_update), 32'd0);
    check("mid_rst_value", 32'(dpot_value), 32'd0);
    acks = 0;
    c = 0;
    while (!dpot_ready && c < 100) begin
      @(negedge clk);
      c++;
      if (ack != 4'b0) acks++;
    end
    check("mid_rst_no_ack", 32'(acks), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 0; m_valid = 1'b0; m_err = 1'b0;
    set_val(0, 8'h55);
    req = 4'b0011;
    serve("post_rst0", 1'b1, a, cyc, upd);
    check("post_rst_ptr", 32'(a), 32'h1);
    serve("post_rst1", 1'b1, a, cyc, upd);

    check("ns_err", 32'(err_b), 32'd0);
    check("ns_idle", 32'(busy_b), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpot_arbiter.md
DPOT_ARBITER -- requirements
Module: dpot_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 1023: clk cycles allowed for the dpot to accept a request.
REQ-003 Parameter SKIP_SAME, default 1: when 1, a request matching the last written value completes without an SPI transfer.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester request level; held high until its ack.
REQ-007 value_i  input  8*NREQ  packed wiper values; requester k uses bits [8k+7:8k].
REQ-008 ack  output  NREQ  one-cycle pulse to the requester whose request completed.
REQ-009 err  output  1  sticky flag: a transfer timed out; cleared only by reset.
REQ-010 busy  output  1  high while a request is granted and not yet acked.
REQ-011 dpot_value  output  8  value presented to the dpot interface.
REQ-012 dpot_update  output  1  update request to the dpot interface.
REQ-013 dpot_ready  input  1  dpot ready, asynchronous to clk (SPI clock domain).

Function
REQ-014 dpot_ready shall pass through a 2-flop synchronizer; all logic shall use only the synchronized value rdy_s.
REQ-015 FSM states: IDLE, GRANT, ISSUE, WAIT, DONE.
REQ-016 IDLE: if any req bit is high and rdy_s=1, select the winner round-robin starting at ptr and go to GRANT; otherwise stay.
REQ-017 Round-robin: the winner is the first set req bit at index ptr, ptr+1, ... modulo NREQ; in DONE, ptr becomes winner+1 modulo NREQ.
REQ-018 GRANT: latch the winner's value into dpot_value and latch the winner index.
REQ-019 GRANT, SKIP_SAME=1, latched value equal to last_val, last_valid=1: go to DONE without asserting dpot_update.
REQ-020 GRANT, otherwise: go to ISSUE.
REQ-021 ISSUE: dpot_update shall be high; remain until rdy_s=0, then go to WAIT.
REQ-022 ISSUE timeout: a cycle counter counts ISSUE cycles; when it reaches TIMEOUT with rdy_s still 1, set err, drop dpot_update and go to DONE.
REQ-023 WAIT: dpot_update shall be low; on rdy_s=1 go to DONE and load last_val from dpot_value with last_valid=1.
REQ-024 DONE: pulse ack[winner] for exactly one cycle, then go to IDLE.
REQ-025 A timed-out transfer shall still ack but shall not update last_val.
REQ-026 dpot_value shall stay stable from GRANT through DONE; value_i changes after GRANT shall have no effect on the current transfer.
REQ-027 A req bit dropped after its grant shall not abort the transfer; ack is still issued.
REQ-028 A requester re-asserting req right after its ack shall not win again while another req bit is set.
REQ-029 busy = (state != IDLE).
REQ-030 Request-to-ack latency for a skipped request: 3 clk cycles (IDLE->GRANT->DONE, ack in DONE).

Reset
REQ-031 On rst low, asynchronously: state=IDLE, ptr=0, ack=0, err=0, dpot_update=0, dpot_value=0, last_valid=0, timeout counter=0, synchronizer flops=1.
REQ-032 Reset asserted mid-transfer shall abandon it with no ack; after release, pending requests re-arbitrate from ptr=0.

Verification
REQ-033 Single request: req=0001, value0=0x5A, dpot model 4 SPI-cycle latency -> one dpot_update burst, dpot_value=0x5A, ack=0001 pulse for one cycle, err=0.
REQ-034 Contention: req=1111 held, with each line deasserted on its own ack -> ack order 0,1,2,3, then ptr=0.
REQ-035 Skip: value0=0x20 written, then req0 again with 0x20 -> ack after 3 cycles, dpot_update never asserted; same test with SKIP_SAME=0 -> full transfer.
REQ-036 Timeout: dpot_ready stuck at 1, TIMEOUT=15 -> dpot_update high for 15 cycles, then err=1, ack pulse, last_val unchanged.
REQ-037 Reset mid-WAIT: rst low during WAIT -> all outputs at reset values immediately, no ack, next request served normally.
REQ-038 Value change: value0 changed from 0x10 to 0x99 one cycle after GRANT -> dpot_value stays 0x10 for the whole transfer.
